// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the two-pass 8/16-bit ALU sequencer.
// Op encoding is {k,i,j,c_in}: k selects logic (1) or arithmetic (0).
package alu_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1110;
    localparam logic [3:0] OP_OR  = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1000;

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational 8-bit ALU: arithmetic is (i ? a : 0) + (j ? ~b : b) + c_in;
// logic ops select on {i,j}. Logic ops report carry and overflow as zero.
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    output logic [BYTE_W-1:0] r,
    output logic              co,
    output logic              ov
);

    logic [BYTE_W-1:0] x;
    logic [BYTE_W-1:0] y;
    logic [BYTE_W:0]   sum;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        x   = op[2] ? a : '0;
        y   = op[1] ? ~b : b;
        sum = {1'b0, x} + {1'b0, y} + {{BYTE_W{1'b0}}, op[0]};
        r   = sum[BYTE_W-1:0];
        co  = sum[BYTE_W];
        ov  = (x[BYTE_W-1] == y[BYTE_W-1]) && (sum[BYTE_W-1] != x[BYTE_W-1]);
        if (op[3]) begin
            co = 1'b0;
            ov = 1'b0;
            case (op[2:1])
                2'b11:   r = a & b;
                2'b01:   r = a | b;
                2'b00:   r = a ^ b;
                default: r = ~(a ^ b);
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer that runs 8-bit or 16-bit ALU operations
// through one shared 8-bit ALU, low byte first, carry chained between passes.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDE_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  op,
    input  logic        wide,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] r,
    output logic        c,
    output logic        z,
    output logic        v,
    output logic        n
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  op_q;
    logic        wide_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        carry_q;
    logic        wide_pass;

    logic [3:0]        alu_op;
    logic [BYTE_W-1:0] alu_a;
    logic [BYTE_W-1:0] alu_b;
    logic [BYTE_W-1:0] alu_r;
    logic              alu_co;
    logic              alu_ov;

    assign wide_pass = (WIDE_EN != 0) && wide_q;
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);

    alu_sequencer_alu u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .r  (alu_r),
        .co (alu_co),
        .ov (alu_ov)
    );

    always_comb begin
        state_next = state;
        alu_op     = op_q;
        alu_a      = a_q[7:0];
        alu_b      = b_q[7:0];
        case (state)
            IDLE: if (req_valid) state_next = LO;
            LO:   state_next = wide_pass ? HI : DONE;
            HI: begin
                alu_a      = a_q[15:8];
                alu_b      = b_q[15:8];
                // Logic ops keep their own c_in bit; arithmetic chains the low-pass carry.
                alu_op     = {op_q[3:1], op_q[3] ? op_q[0] : carry_q};
                state_next = DONE;
            end
            DONE: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            wide_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            r       <= '0;
            c       <= 1'b0;
            z       <= 1'b0;
            v       <= 1'b0;
            n       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q   <= op;
                    wide_q <= wide;
                    a_q    <= a;
                    b_q    <= b;
                end
                LO: begin
                    r       <= {8'h00, alu_r};
                    carry_q <= alu_co;
                    if (!wide_pass) begin
                        c <= alu_co;
                        v <= alu_ov;
                        z <= (alu_r == '0);
                        n <= alu_r[BYTE_W-1];
                    end
                end
                HI: begin
                    r[15:8] <= alu_r;
                    c       <= alu_co;
                    v       <= alu_ov;
                    z       <= (alu_r == '0) && (r[7:0] == 8'h00);
                    n       <= alu_r[BYTE_W-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: hand-computed vectors, latency,
// backpressure, and reset in the middle of a 16-bit operation.
module tb_alu_sequencer;

    localparam logic [3:0] ADD = 4'b0100;
    localparam logic [3:0] SUB = 4'b0111;
    localparam logic [3:0] AND = 4'b1110;
    localparam logic [3:0] OR  = 4'b1010;
    localparam logic [3:0] XOR = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  op = 4'h0;
    logic        wide = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] r;
    logic        c, z, v, n;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer #(.WIDE_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .wide      (wide),
        .a         (a),
        .b         (b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .r         (r),
        .c         (c),
        .z         (z),
        .v         (v),
        .n         (n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits from the acceptance edge for rsp_valid; returns cycles counted at negedges.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
    endtask

    task automatic run(input string tag, input logic [3:0] t_op, input logic t_wide,
                       input logic [15:0] t_a, input logic [15:0] t_b,
                       input logic [15:0] e_r, input logic e_c, input logic e_z,
                       input logic e_v, input logic e_n, input int e_lat);
        int lat;
        @(negedge clk);
        check({tag, ".req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        op = t_op; wide = t_wide; a = t_a; b = t_b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        a = 16'hA5A5;
        b = 16'h5A5A;
        op = 4'hF;
        wait_rsp(lat);
        check({tag, ".lat"}, lat, e_lat);
        check({tag, ".r"}, r, e_r);
        check({tag, ".c"}, c, e_c);
        check({tag, ".z"}, z, e_z);
        check({tag, ".v"}, v, e_v);
        check({tag, ".n"}, n, e_n);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;

        // Reset state
        #12;
        check("rst.r", r, 16'h0000);
        check("rst.flags", {c, z, v, n}, 4'b0000);
        check("rst.rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.req_ready", req_ready, 1'b1);

        // Directed vectors:   op   wide  a        b        r        c     z     v     n     lat
        run("add8",     ADD, 1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        run("add16",    ADD, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run("sub16_m1", SUB, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        run("sub16_eq", SUB, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 3);
        run("and16",    AND, 1'b1, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run("add8_ovf", ADD, 1'b0, 16'hAB7F, 16'hCD01, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        run("sub8_eq",  SUB, 1'b0, 16'h7705, 16'h1105, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        run("or16",     OR,  1'b1, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run("xor16",    XOR, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        run("add16_wr", ADD, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 3);
        run("add16_ov", ADD, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 3);

        // Backpressure: response held 5 cycles while a new request waits
        @(negedge clk);
        req_valid = 1'b1; op = ADD; wide = 1'b1; a = 16'h1111; b = 16'h2222;
        @(posedge clk);
        #1;
        op = ADD; wide = 1'b0; a = 16'h0010; b = 16'h0020;
        wait_rsp(lat);
        check("bp.lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            check("bp.r", r, 16'h3333);
            check("bp.flags", {c, z, v, n}, 4'b0000);
            check("bp.rsp_valid", rsp_valid, 1'b1);
            check("bp.req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(lat);
        check("bp_next.lat", lat, 2);
        check("bp_next.r", r, 16'h0030);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset pulsed during the HI pass of a 16-bit ADD
        @(negedge clk);
        req_valid = 1'b1; op = ADD; wide = 1'b1; a = 16'h1234; b = 16'h0001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst.r", r, 16'h0000);
        check("mid_rst.flags", {c, z, v, n}, 4'b0000);
        check("mid_rst.rsp_valid", rsp_valid, 1'b0);
        check("mid_rst.req_ready", req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mid_rst.no_rsp", seen, 0);
        run("after_rst", ADD, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
